// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Receive buffer that sits directly behind RxControl. Each byte RxControl
//   flags as ready is captured once, together with its frame, parity and
//   overrun flags. The byte is acknowledged with an active-low read strobe.
//   The host reads the bytes from a show-ahead FIFO.
//
// Ports
//   clk_in, reset_in      clock, asynchronous active-high reset
//   rx_*_in               byte, error flags and ready flag from RxControl
//   rx_n_rd_out           read strobe to RxControl (low = byte taken)
//   rd_en_in              host pop strobe
//   data_out, *_err_out   head entry (valid while empty_out = 0)
//   empty_out, full_out   occupancy status
//   count_out             number of entries held, 0 .. 2**DEPTH_LOG2
//   overflow_out          sticky: set when a byte is dropped on a full FIFO
//   clr_ovf_in            clears overflow_out
//
// Optional build macro UART_RX_FIFO_THRESH_EN
//   Adds thresh_in and level_irq_out. level_irq_out is a registered flag that
//   is high while count_out >= thresh_in, provided thresh_in is not 0.
module uart_rx_fifo #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk_in,
   input  logic                  reset_in,
   input  logic [7:0]            rx_data_in,
   input  logic                  rx_frame_err_in,
   input  logic                  rx_parity_err_in,
   input  logic                  rx_overrun_err_in,
   input  logic                  rx_rdy_in,
   output logic                  rx_n_rd_out,
   input  logic                  rd_en_in,
`ifdef UART_RX_FIFO_THRESH_EN
   input  logic [DEPTH_LOG2:0]   thresh_in,
   output logic                  level_irq_out,
`endif
   output logic [7:0]            data_out,
   output logic                  frame_err_out,
   output logic                  parity_err_out,
   output logic                  overrun_err_out,
   output logic                  empty_out,
   output logic                  full_out,
   output logic [DEPTH_LOG2:0]   count_out,
   output logic                  overflow_out,
   input  logic                  clr_ovf_in
);

   localparam int                 DEPTH     = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] CNT_ONE   = 1;
   localparam logic [DEPTH_LOG2:0] CNT_FULL  = (DEPTH_LOG2 + 1)'(DEPTH);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;

   typedef enum logic [1:0] {IDLE, CAPTURE, ACK, RELEASE} state_t;

   state_t                  state_q, state_d;
   logic                    n_rd_q, n_rd_d;
   logic [DEPTH_LOG2-1:0]   wr_ptr_q, rd_ptr_q;
   logic [DEPTH_LOG2:0]     count_q, count_d;
   logic                    empty_q, full_q, overflow_q;
   logic [10:0]             head_q;
   logic [10:0]             mem [DEPTH];

   logic                    capture;
   logic                    push;
   logic                    pop;
   logic [10:0]             wdata;

   assign wdata   = {rx_overrun_err_in, rx_parity_err_in, rx_frame_err_in, rx_data_in};
   assign capture = (state_q == CAPTURE);
   assign pop     = rd_en_in && !empty_q;
   // A full FIFO still takes the byte if the host frees a slot on the same edge.
   assign push    = capture && (!full_q || pop);

   // Capture FSM: next state and registered read strobe
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (rx_rdy_in) state_d = CAPTURE;
         CAPTURE: state_d = ACK;
         ACK:     if (!rx_rdy_in) state_d = RELEASE;
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Strobe is low exactly while the FSM sits in ACK.
      n_rd_d = (state_d != ACK);
   end

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         state_q <= IDLE;
         n_rd_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         n_rd_q  <= n_rd_d;
      end
   end

   // Occupancy next state
   always_comb begin
      count_d = count_q;
      if (push && !pop)
         count_d = count_q + CNT_ONE;
      else if (pop && !push)
         count_d = count_q - CNT_ONE;
   end

   // Storage array, no reset so it can map onto block RAM
   always_ff @(posedge clk_in) begin
      if (push)
         mem[wr_ptr_q] <= wdata;
   end

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
         overflow_q <= 1'b0;
         head_q     <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         count_q <= count_d;
         empty_q <= (count_d == '0);
         full_q  <= (count_d == CNT_FULL);
         // A set from a refused push wins over a simultaneous clear.
         if (capture && !push)
            overflow_q <= 1'b1;
         else if (clr_ovf_in)
            overflow_q <= 1'b0;
         // Head register: bypass the incoming byte when it becomes the new
         // head (FIFO empty, or its only entry is popped on this edge).
         // Otherwise a pop loads the entry behind the current head.
         if (push && (empty_q || (pop && count_q == CNT_ONE)))
            head_q <= wdata;
         else if (pop)
            head_q <= mem[rd_ptr_q + PTR_ONE];
      end
   end

`ifdef UART_RX_FIFO_THRESH_EN
   logic level_irq_q;

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in)
         level_irq_q <= 1'b0;
      else
         level_irq_q <= (thresh_in != '0) && (count_q >= thresh_in);
   end

   assign level_irq_out = level_irq_q;
`endif

   assign rx_n_rd_out     = n_rd_q;
   assign data_out        = head_q[7:0];
   assign frame_err_out   = head_q[8];
   assign parity_err_out  = head_q[9];
   assign overrun_err_out = head_q[10];
   assign empty_out       = empty_q;
   assign full_out        = full_q;
   assign count_out       = count_q;
   assign overflow_out    = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a table of single-byte vectors plus
// hand-written sequences for fill/overflow, push-while-full, async reset and
// (when built with UART_RX_FIFO_THRESH_EN) the level interrupt.
module tb_uart_rx_fifo;

   logic       clk = 1'b0;
   logic       reset_in;
   logic [7:0] rx_data_in;
   logic       rx_frame_err_in, rx_parity_err_in, rx_overrun_err_in;
   logic       rx_rdy_in;
   logic       rx_n_rd_out;
   logic       rd_en_in;
   logic [7:0] data_out;
   logic       frame_err_out, parity_err_out, overrun_err_out;
   logic       empty_out, full_out;
   logic [4:0] count_out;
   logic       overflow_out;
   logic       clr_ovf_in;
`ifdef UART_RX_FIFO_THRESH_EN
   logic [4:0] thresh_in;
   logic       level_irq_out;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   uart_rx_fifo #(.DEPTH_LOG2(4)) dut (
      .clk_in            (clk),
      .reset_in          (reset_in),
      .rx_data_in        (rx_data_in),
      .rx_frame_err_in   (rx_frame_err_in),
      .rx_parity_err_in  (rx_parity_err_in),
      .rx_overrun_err_in (rx_overrun_err_in),
      .rx_rdy_in         (rx_rdy_in),
      .rx_n_rd_out       (rx_n_rd_out),
      .rd_en_in          (rd_en_in),
`ifdef UART_RX_FIFO_THRESH_EN
      .thresh_in         (thresh_in),
      .level_irq_out     (level_irq_out),
`endif
      .data_out          (data_out),
      .frame_err_out     (frame_err_out),
      .parity_err_out    (parity_err_out),
      .overrun_err_out   (overrun_err_out),
      .empty_out         (empty_out),
      .full_out          (full_out),
      .count_out         (count_out),
      .overflow_out      (overflow_out),
      .clr_ovf_in        (clr_ovf_in)
   );

   typedef struct {
      logic [7:0] d;
      logic       fe, pe, oe;
      logic [7:0] exp_d;
      logic       exp_fe, exp_pe, exp_oe;
   } vec_t;

   vec_t vecs [4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      #1 reset_in = 1'b1;
      tick();
      reset_in = 1'b0;
      tick();
   endtask

   task automatic set_byte(input logic [7:0] d, input logic fe, input logic pe, input logic oe);
      rx_data_in        = d;
      rx_frame_err_in   = fe;
      rx_parity_err_in  = pe;
      rx_overrun_err_in = oe;
      rx_rdy_in         = 1'b1;
   endtask

   task automatic wait_ack_low();
      int n = 0;
      while (rx_n_rd_out !== 1'b0 && n < 10) begin
         tick();
         n++;
      end
      chk("ack_fall", rx_n_rd_out, 0);
   endtask

   // RxControl model: hold ready 3 cycles after the strobe falls, then drop it.
   task automatic finish_ack();
      int n = 0;
      logic held = 1'b1;
      wait_ack_low();
      repeat (3) begin
         tick();
         if (rx_n_rd_out !== 1'b0) held = 1'b0;
      end
      chk("ack_hold", held, 1);
      rx_rdy_in = 1'b0;
      while (rx_n_rd_out !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      chk("ack_release", rx_n_rd_out, 1);
      tick();
   endtask

   task automatic send_byte(input logic [7:0] d, input logic fe, input logic pe, input logic oe);
      set_byte(d, fe, pe, oe);
      finish_ack();
      $display("[TB] rx byte %02h acknowledged, count=%0d", d, count_out);
   endtask

   task automatic pop_chk(input logic [7:0] exp);
      chk("pop_empty", empty_out, 0);
      chk("pop_data", data_out, exp);
      rd_en_in = 1'b1;
      tick();
      rd_en_in = 1'b0;
      $display("[TB] pop %02h", exp);
   endtask

   initial begin
      vecs[0] = '{8'h55, 1'b1, 1'b1, 1'b0, 8'h55, 1'b1, 1'b1, 1'b0};
      vecs[1] = '{8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
      vecs[2] = '{8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1};
      vecs[3] = '{8'h80, 1'b0, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};

      reset_in = 1'b1;
      rx_data_in = 8'h00;
      rx_frame_err_in = 1'b0; rx_parity_err_in = 1'b0; rx_overrun_err_in = 1'b0;
      rx_rdy_in = 1'b0; rd_en_in = 1'b0; clr_ovf_in = 1'b0;
`ifdef UART_RX_FIFO_THRESH_EN
      thresh_in = 5'd4;
`endif
      #22;
      // Reset state
      chk("rst_n_rd", rx_n_rd_out, 1);
      chk("rst_empty", empty_out, 1);
      chk("rst_full", full_out, 0);
      chk("rst_count", count_out, 0);
      chk("rst_ovf", overflow_out, 0);
      chk("rst_data", {overrun_err_out, parity_err_out, frame_err_out, data_out}, 0);
      reset_in = 1'b0;
      tick();

      // 1: single byte
      send_byte(8'hA5, 1'b0, 1'b0, 1'b0);
      chk("t1_count", count_out, 1);
      chk("t1_empty", empty_out, 0);
      chk("t1_head", {overrun_err_out, parity_err_out, frame_err_out, data_out}, 11'h0A5);

      // Table: one byte in, check head and flags, pop back to empty
      do_reset();
      for (int i = 0; i < 4; i++) begin
         send_byte(vecs[i].d, vecs[i].fe, vecs[i].pe, vecs[i].oe);
         chk("vec_count", count_out, 1);
         chk("vec_data", data_out, vecs[i].exp_d);
         chk("vec_fe", frame_err_out, vecs[i].exp_fe);
         chk("vec_pe", parity_err_out, vecs[i].exp_pe);
         chk("vec_oe", overrun_err_out, vecs[i].exp_oe);
         pop_chk(vecs[i].exp_d);
         chk("vec_empty_after", empty_out, 1);
      end

      // 2: fill, overflow, drain
      do_reset();
      for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0, 1'b0, 1'b0);
      chk("t2_full", full_out, 1);
      chk("t2_count", count_out, 16);
      chk("t2_ovf_before", overflow_out, 0);
      send_byte(8'hFF, 1'b0, 1'b0, 1'b0);
      chk("t2_ovf", overflow_out, 1);
      chk("t2_count_after", count_out, 16);
      chk("t2_full_after", full_out, 1);
      for (int i = 0; i < 16; i++) pop_chk(8'(i));
      chk("t2_empty", empty_out, 1);
      chk("t2_count0", count_out, 0);
      rd_en_in = 1'b1;          // pop on empty is ignored
      tick();
      rd_en_in = 1'b0;
      chk("t2_empty_pop", count_out, 0);
      clr_ovf_in = 1'b1;
      tick();
      clr_ovf_in = 1'b0;
      chk("t2_ovf_clr", overflow_out, 0);

      // 3: push on the same edge as a pop while full
      for (int i = 0; i < 16; i++) send_byte(8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
      chk("t3_full", full_out, 1);
      set_byte(8'h3C, 1'b0, 1'b0, 1'b0);
      tick();                   // FSM now in CAPTURE
      rd_en_in = 1'b1;
      tick();                   // push and pop together
      rd_en_in = 1'b0;
      chk("t3_count", count_out, 16);
      chk("t3_ovf", overflow_out, 0);
      chk("t3_head", data_out, 8'h11);
      finish_ack();
      for (int i = 1; i < 16; i++) pop_chk(8'(8'h10 + i));
      pop_chk(8'h3C);
      chk("t3_empty", empty_out, 1);

      // 5: asynchronous reset while in ACK
      do_reset();
      for (int i = 0; i < 4; i++) send_byte(8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
      set_byte(8'h24, 1'b0, 1'b0, 1'b0);
      wait_ack_low();
      chk("t5_count5", count_out, 5);
      #1 reset_in = 1'b1;
      #1;
      chk("t5_n_rd", rx_n_rd_out, 1);
      chk("t5_count", count_out, 0);
      chk("t5_empty", empty_out, 1);
      rx_rdy_in = 1'b0;
      tick();
      reset_in = 1'b0;
      tick();
      chk("t5_count_post", count_out, 0);

`ifdef UART_RX_FIFO_THRESH_EN
      // 6: level interrupt
      for (int i = 0; i < 3; i++) send_byte(8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
      chk("t6_irq_low", level_irq_out, 0);
      send_byte(8'h43, 1'b0, 1'b0, 1'b0);
      chk("t6_irq_high", level_irq_out, 1);
      pop_chk(8'h40);
      tick();
      chk("t6_irq_fall", level_irq_out, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
